// File: rtl/gpr_wb_ctrl.sv
// Write-back controller: merges ALU results and buffered LSU load results into the single
// registered GPR write port. Define WB_BUSY_EN to add the per-register busy scoreboard.
module gpr_wb_ctrl #(
  parameter int REG_ADD_WIDTH  = 5,
  parameter int REG_DAT_WIDTH  = 32,
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           alu_valid_i,
  output logic                           alu_ready_o,
  input  logic [REG_ADD_WIDTH-1:0]       alu_addr_i,
  input  logic [REG_DAT_WIDTH-1:0]       alu_data_i,
  input  logic                           lsu_valid_i,
  output logic                           lsu_ready_o,
  input  logic [REG_ADD_WIDTH-1:0]       lsu_addr_i,
  input  logic [REG_DAT_WIDTH-1:0]       lsu_data_i,
  output logic                           wre_o,
  output logic [REG_ADD_WIDTH-1:0]       wr_addr_o,
  output logic [REG_DAT_WIDTH-1:0]       wr_data_o,
  output logic [$clog2(LSU_FIFO_DEPTH):0] fifo_cnt_o
`ifdef WB_BUSY_EN
  ,
  input  logic                           alloc_i,
  input  logic [REG_ADD_WIDTH-1:0]       alloc_addr_i,
  output logic [2**REG_ADD_WIDTH-1:0]    busy_vec_o
`endif
);

  localparam int PTR_W    = $clog2(LSU_FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [REG_ADD_WIDTH-1:0] fifo_addr_mem [LSU_FIFO_DEPTH];
  logic [REG_DAT_WIDTH-1:0] fifo_data_mem [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         cnt;
  logic [STARVE_W-1:0]      starve_cnt;

  logic                     fifo_req;
  logic                     starved;
  logic                     alu_win;
  logic                     fifo_win;
  logic                     push;
  logic [REG_ADD_WIDTH-1:0] win_addr;
  logic [REG_DAT_WIDTH-1:0] win_data;

  assign lsu_ready_o = (cnt < CNT_W'(LSU_FIFO_DEPTH));
  assign alu_ready_o = alu_win;
  assign fifo_cnt_o  = cnt;

  // The arbiter only sees registered FIFO state, so a same-cycle push is never bypassed.
  always_comb begin
    fifo_req = (cnt != '0);
    starved  = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    alu_win  = alu_valid_i && (!fifo_req || starved);
    fifo_win = fifo_req && !alu_win;
    push     = lsu_valid_i && lsu_ready_o;
    win_addr = alu_win ? alu_addr_i : fifo_addr_mem[rd_ptr];
    win_data = alu_win ? alu_data_i : fifo_data_mem[rd_ptr];
  end

  // NOTE: FIFO storage has no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_mem[wr_ptr] <= lsu_addr_i;
      fifo_data_mem[wr_ptr] <= lsu_data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      starve_cnt <= '0;
      wre_o      <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (fifo_win) rd_ptr <= rd_ptr + 1'b1;

      case ({push, fifo_win})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if (alu_valid_i && !alu_win) begin
        if (!starved) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end

      // r0 is read-only: the write is consumed but the enable stays low.
      if (alu_win || fifo_win) begin
        wre_o     <= (win_addr != '0);
        wr_addr_o <= win_addr;
        wr_data_o <= win_data;
      end else begin
        wre_o     <= 1'b0;
      end
    end
  end

`ifdef WB_BUSY_EN
  logic [2**REG_ADD_WIDTH-1:0] busy_next;

  // A clear lands on the same edge that raises wre_o; a new allocation to that register wins.
  always_comb begin
    busy_next = busy_vec_o;
    if ((alu_win || fifo_win) && (win_addr != '0)) busy_next[win_addr] = 1'b0;
    if (alloc_i) busy_next[alloc_addr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) busy_vec_o <= '0;
    else          busy_vec_o <= busy_next;
  end
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed self-checking bench for gpr_wb_ctrl (default depth 4, starvation limit 3).
module tb_gpr_wb_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        wre_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [2:0]  fifo_cnt_o;
`ifdef WB_BUSY_EN
  logic        alloc_i;
  logic [4:0]  alloc_addr_i;
  logic [31:0] busy_vec_o;
`endif

  int checks   = 0;
  int failures = 0;
  int alu_n    = 0;
  int lsu_push = 0;
  int lsu_pop  = 0;

  gpr_wb_ctrl dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .alu_valid_i (alu_valid_i),
    .alu_ready_o (alu_ready_o),
    .alu_addr_i  (alu_addr_i),
    .alu_data_i  (alu_data_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_data_i  (lsu_data_i),
    .wre_o       (wre_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .fifo_cnt_o  (fifo_cnt_o)
`ifdef WB_BUSY_EN
    ,
    .alloc_i     (alloc_i),
    .alloc_addr_i(alloc_addr_i),
    .busy_vec_o  (busy_vec_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0;
    alu_addr_i  = '0;
    alu_data_i  = '0;
    lsu_valid_i = 1'b0;
    lsu_addr_i  = '0;
    lsu_data_i  = '0;
`ifdef WB_BUSY_EN
    alloc_i      = 1'b0;
    alloc_addr_i = '0;
`endif
  endtask

  // ALU (r1) and LSU (r2) both offer every cycle starting from an empty FIFO with a
  // cleared starvation counter. Hand-derived winner pattern: ALU on cycle 0 (FIFO empty),
  // then three LSU writes followed by one forced ALU write, i.e. ALU when cyc%4==0.
  task automatic run_pressure(input int cycles);
    logic exp_alu;
    logic pushed;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      alu_valid_i = 1'b1;
      alu_addr_i  = 5'd1;
      alu_data_i  = 32'hA000 + alu_n;
      lsu_valid_i = 1'b1;
      lsu_addr_i  = 5'd2;
      lsu_data_i  = 32'hB000 + lsu_push;
      #1;
      exp_alu = (cyc % 4 == 0);
      check("press_alu_ready", alu_ready_o, exp_alu);
      pushed = lsu_ready_o;
      @(posedge clk_i);
      #2;
      if (pushed) lsu_push++;
      check("press_wre", wre_o, 1);
      if (exp_alu) begin
        check("press_alu_data", wr_data_o, 32'hA000 + alu_n);
        check("press_alu_addr", wr_addr_o, 1);
        alu_n++;
      end else begin
        check("press_lsu_data", wr_data_o, 32'hB000 + lsu_pop);
        check("press_lsu_addr", wr_addr_o, 2);
        lsu_pop++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n_i = 1'b0;
    #12;
    // Test 1: reset state, then a single ALU write with one cycle latency.
    check("rst_wre", wre_o, 0);
    check("rst_lsu_ready", lsu_ready_o, 1);
    check("rst_cnt", fifo_cnt_o, 0);
    check("rst_addr", wr_addr_o, 0);
    check("rst_data", wr_data_o, 0);
    #4 rst_n_i = 1'b1;
    step();
    check("idle_wre", wre_o, 0);
    alu_valid_i = 1'b1;
    alu_addr_i  = 5'd5;
    alu_data_i  = 32'hA5A5;
    #1;
    check("t1_alu_ready", alu_ready_o, 1);
    step();
    idle_inputs();
    check("t1_wre", wre_o, 1);
    check("t1_addr", wr_addr_o, 5);
    check("t1_data", wr_data_o, 32'hA5A5);
    step();
    check("t1_wre_idle", wre_o, 0);
    check("t1_addr_hold", wr_addr_o, 5);
    check("t1_data_hold", wr_data_o, 32'hA5A5);

    // Test 2: single LSU result with ALU idle drains on the following cycle.
    lsu_valid_i = 1'b1;
    lsu_addr_i  = 5'd9;
    lsu_data_i  = 32'h1234;
    step();
    idle_inputs();
    check("t2_cnt_push", fifo_cnt_o, 1);
    check("t2_no_bypass", wre_o, 0);
    step();
    check("t2_wre", wre_o, 1);
    check("t2_addr", wr_addr_o, 9);
    check("t2_data", wr_data_o, 32'h1234);
    check("t2_cnt_pop", fifo_cnt_o, 0);

    // Test 3: starvation pattern under continuous pressure; FIFO fills to 4 after 13 cycles.
    run_pressure(13);
    check("t3_cnt_full", fifo_cnt_o, 4);
    check("t3_ready_full", lsu_ready_o, 0);
    // Full FIFO refuses a push; drain the four entries in order, one per cycle.
    lsu_valid_i = 1'b1;
    lsu_addr_i  = 5'd2;
    lsu_data_i  = 32'hDEAD;
    step();
    idle_inputs();
    check("t3_drain_data0", wr_data_o, 32'hB000 + lsu_pop);
    lsu_pop++;
    check("t3_cnt_no_push", fifo_cnt_o, 3);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t3_drain_wre", wre_o, 1);
      check("t3_drain_data", wr_data_o, 32'hB000 + lsu_pop);
      lsu_pop++;
    end
    check("t3_cnt_empty", fifo_cnt_o, 0);
    check("t3_ready_empty", lsu_ready_o, 1);
    step();
    check("t3_idle_wre", wre_o, 0);

    // Test 4: writes to r0 are consumed without asserting wre_o.
    alu_valid_i = 1'b1;
    alu_addr_i  = 5'd0;
    alu_data_i  = 32'hFFFF;
    #1;
    check("t4_alu_ready_r0", alu_ready_o, 1);
    step();
    idle_inputs();
    check("t4_alu_r0_wre", wre_o, 0);
    lsu_valid_i = 1'b1;
    lsu_addr_i  = 5'd0;
    lsu_data_i  = 32'h7777;
    step();
    idle_inputs();
    check("t4_lsu_r0_cnt", fifo_cnt_o, 1);
    step();
    check("t4_lsu_r0_wre", wre_o, 0);
    check("t4_lsu_r0_pop", fifo_cnt_o, 0);

    // Test 5: asynchronous reset with three buffered entries drops them all.
    run_pressure(9);
    check("t5_cnt_before", fifo_cnt_o, 3);
    check("t5_wre_before", wre_o, 1);
    #1 rst_n_i = 1'b0;
    #1;
    check("t5_rst_wre", wre_o, 0);
    check("t5_rst_cnt", fifo_cnt_o, 0);
    check("t5_rst_ready", lsu_ready_o, 1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_stale_wre", wre_o, 0);
      check("t5_no_stale_cnt", fifo_cnt_o, 0);
    end

`ifdef WB_BUSY_EN
    // Test 6: busy bit set by alloc, cleared on the cycle the write issues.
    alloc_i      = 1'b1;
    alloc_addr_i = 5'd7;
    step();
    idle_inputs();
    check("t6_busy_set", busy_vec_o[7], 1);
    lsu_valid_i = 1'b1;
    lsu_addr_i  = 5'd7;
    lsu_data_i  = 32'h4242;
    step();
    idle_inputs();
    check("t6_busy_pending", busy_vec_o[7], 1);
    step();
    check("t6_wre", wre_o, 1);
    check("t6_busy_clear", busy_vec_o[7], 0);
    check("t6_busy_r0", busy_vec_o[0], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end

endmodule
